// File: rtl/apb_pkg.sv
// Shared types and default widths for the arbitrated APB master.
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;
  localparam int TO_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    if (update && (|gnt)) last_d = gnt[1];
  end

  // last grant starts at requester 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: round-robin accept, one transfer at a time,
// bounded ACCESS wait with timeout error response.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  apb_state_e          state_q, state_d;
  req_id_e             gid_q, gid_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic                rsp0_err_q, rsp0_err_d;
  logic                rsp1_err_q, rsp1_err_d;
  logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;

  logic [1:0]          arb_req;
  logic [1:0]          gnt;
  logic                arb_update;
  logic                done;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_rdata;

  assign arb_req    = {req1_valid, req0_valid} & {2{state_q == IDLE}};
  assign arb_update = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .update (arb_update),
    .gnt    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // The APB address/control registers double as the latched command.
  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done      = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;

    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          gid_d    = gnt[1] ? REQ1 : REQ0;
          pwrite_d = gnt[1] ? req1_write : req0_write;
          paddr_d  = gnt[1] ? req1_addr  : req0_addr;
          pwdata_d = gnt[1] ? req1_wdata : req0_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          done      = 1'b1;
          rsp_rdata = pwrite_q ? '0 : prdata;
          state_d   = IDLE;
        end else if (cnt_q == TO_LAST) begin
          done    = 1'b1;
          rsp_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);

    rsp0_valid_d = done && (gid_q == REQ0);
    rsp1_valid_d = done && (gid_q == REQ1);
    rsp0_rdata_d = rsp0_valid_d ? rsp_rdata : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? rsp_rdata : rsp1_rdata_q;
    rsp0_err_d   = rsp0_valid_d ? rsp_err   : rsp0_err_q;
    rsp1_err_d   = rsp1_valid_d ? rsp_err   : rsp1_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gid_q        <= REQ0;
      cnt_q        <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gid_q        <= gid_d;
      cnt_q        <= cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_err   = rsp1_err_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Scoreboard bench for apb_arb_master: reference model predicts grant order,
// APB phases, response data/error and latency; monitors compare independently.
module tb_apb_arb_master;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_write = 1'b0, req0_ready;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_write = 1'b0, req1_ready;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;

  always #5 clk = ~clk;

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wt;    // responder wait cycles before pready
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    bit            err;
    int            lat;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    bit            wr;
    logic [DW-1:0] wdata;
    int            len;   // expected ACCESS cycles; 0 = aborted, unchecked
  } apb_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  apb_t apb_q[$];
  int   wq[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int pending = 0;
  bit last_m = 1'b1;
  logic [DW-1:0] mem_m [32];
  logic [DW-1:0] mem_s [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // APB responder: wait count taken per transfer at SETUP, writes commit on pready.
  initial begin : responder
    int cur_wait, acc_cnt;
    cur_wait = 0;
    acc_cnt  = 0;
    forever begin
      @(negedge clk);
      if (psel && !penable) begin
        cur_wait = (wq.size() > 0) ? wq.pop_front() : 0;
        acc_cnt  = 0;
        pready   = 1'b0;
        prdata   = $urandom;
      end else if (psel && penable) begin
        if (acc_cnt == cur_wait) begin
          pready = 1'b1;
          prdata = pwrite ? $urandom : mem_s[paddr];
        end else begin
          pready = 1'b0;
          prdata = $urandom;
        end
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        acc_cnt = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (!rst && psel && penable && pready && pwrite) mem_s[paddr] = pwdata;
  end

  // Monitor: APB phase checks, accept timestamps, response scoreboard.
  initial begin : monitor
    apb_t cur;
    exp_t e;
    int acc_len, acc0, acc1;
    bit have;
    acc_len = 0; acc0 = 0; acc1 = 0; have = 1'b0;
    cur = '{addr: '0, wr: 1'b0, wdata: '0, len: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_len = 0;
        have    = 1'b0;
      end else begin
        if (req0_valid && req0_ready) acc0 = cyc;
        if (req1_valid && req1_ready) acc1 = cyc;
        chk("ready_onehot", {63'd0, req0_ready && req1_ready}, 64'd0);
        if (psel && !penable) begin
          if (apb_q.size() == 0) fail_now("unexpected_setup");
          else begin
            cur  = apb_q.pop_front();
            have = 1'b1;
            chk("setup_addr", {59'd0, paddr}, {59'd0, cur.addr});
            chk("setup_write", {63'd0, pwrite}, {63'd0, cur.wr});
            if (cur.wr) chk("setup_wdata", {32'd0, pwdata}, {32'd0, cur.wdata});
          end
        end else if (psel && penable) begin
          acc_len++;
          if (have) begin
            chk("access_addr", {59'd0, paddr}, {59'd0, cur.addr});
            chk("access_write", {63'd0, pwrite}, {63'd0, cur.wr});
          end
        end else if (!psel) begin
          chk("idle_penable", {63'd0, penable}, 64'd0);
          if (acc_len > 0 && have && cur.len != 0)
            chk("access_len", acc_len, cur.len);
          acc_len = 0;
          have    = 1'b0;
        end
        chk("rsp_both", {63'd0, rsp0_valid && rsp1_valid}, 64'd0);
        if (rsp0_valid) begin
          if (exp_q0.size() == 0) fail_now("rsp0_unexpected");
          else begin
            e = exp_q0.pop_front();
            chk("rsp0_rdata", {32'd0, rsp0_rdata}, {32'd0, e.rdata});
            chk("rsp0_err", {63'd0, rsp0_err}, {63'd0, e.err});
            chk("rsp0_latency", cyc - acc0, e.lat);
            pending--;
          end
        end
        if (rsp1_valid) begin
          if (exp_q1.size() == 0) fail_now("rsp1_unexpected");
          else begin
            e = exp_q1.pop_front();
            chk("rsp1_rdata", {32'd0, rsp1_rdata}, {32'd0, e.rdata});
            chk("rsp1_err", {63'd0, rsp1_err}, {63'd0, e.err});
            chk("rsp1_latency", cyc - acc1, e.lat);
            pending--;
          end
        end
      end
    end
  end

  // Reference model: order the commands by the round-robin rule and predict
  // each outcome from the responder's wait count and the memory image.
  task automatic plan(input int r, input cmd_t c, input bit expect_rsp);
    apb_t a;
    exp_t e;
    int len;
    len = (c.wt + 1 < TO) ? c.wt + 1 : TO;
    wq.push_back(c.wt);
    a = '{addr: c.addr, wr: c.wr, wdata: c.wdata, len: expect_rsp ? len : 0};
    apb_q.push_back(a);
    if (expect_rsp) begin
      e.err   = (c.wt >= TO);
      e.rdata = (e.err || c.wr) ? '0 : mem_m[c.addr];
      e.lat   = 2 + len;
      if (!e.err && c.wr) mem_m[c.addr] = c.wdata;
      if (r == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      pending++;
    end
  endtask

  task automatic drive_and_wait(input bit v0, input bit v1, input cmd_t c0, input cmd_t c1);
    bit a0, a1;
    @(posedge clk); #1;
    req0_valid = v0; req0_write = c0.wr; req0_addr = c0.addr; req0_wdata = c0.wdata;
    req1_valid = v1; req1_write = c1.wr; req1_addr = c1.addr; req1_wdata = c1.wdata;
    for (int k = 0; k < 200 && (req0_valid || req1_valid); k++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    if (req0_valid || req1_valid) begin
      fail_now("accept_timeout");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic run_round(input bit v0, input bit v1, input cmd_t c0, input cmd_t c1);
    int first;
    if (v0 && v1) begin
      first = last_m ? 0 : 1;
      plan(first, first ? c1 : c0, 1'b1);
      plan(1 - first, first ? c0 : c1, 1'b1);
      last_m = (first == 0);
    end else if (v0) begin
      plan(0, c0, 1'b1);
      last_m = 1'b0;
    end else if (v1) begin
      plan(1, c1, 1'b1);
      last_m = 1'b1;
    end
    drive_and_wait(v0, v1, c0, c1);
    for (int k = 0; k < 400 && pending > 0; k++) @(negedge clk);
    if (pending > 0) begin
      fail_now("response_timeout");
      pending = 0;
      exp_q0.delete(); exp_q1.delete(); apb_q.delete(); wq.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic cmd_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int wt);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.wt = wt;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    int r, wt;
    r = $urandom_range(0, 9);
    if (r < 6)       wt = $urandom_range(0, 3);
    else if (r < 8)  wt = $urandom_range(4, 14);
    else if (r == 8) wt = TO - 1;
    else             wt = ($urandom_range(0, 1) == 1) ? TO : NEVER;
    return mk($urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom, wt);
  endfunction

  cmd_t z;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_m[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      mem_s[i] = mem_m[i];
    end
    z = mk(1'b0, '0, '0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", {63'd0, psel}, 64'd0);
    chk("rst_penable", {63'd0, penable}, 64'd0);
    chk("rst_pwrite", {63'd0, pwrite}, 64'd0);
    chk("rst_paddr", {59'd0, paddr}, 64'd0);
    chk("rst_pwdata", {32'd0, pwdata}, 64'd0);
    chk("rst_rsp0", {62'd0, rsp0_valid, rsp0_err}, 64'd0);
    chk("rst_rsp1", {62'd0, rsp1_valid, rsp1_err}, 64'd0);
    chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // single write, then read-back with 4 wait cycles
    run_round(1'b1, 1'b0, mk(1'b1, 5'h03, 32'hA5A5_0001, 0), z);
    run_round(1'b0, 1'b1, z, mk(1'b0, 5'h03, 32'h0, 4));
    // contention: three tied rounds give 0,1,0,1,0,1
    for (int i = 0; i < 3; i++)
      run_round(1'b1, 1'b1, mk(1'b1, AW'(8 + i), 32'hC0DE_0000 + 32'(i), 1),
                            mk(1'b0, AW'(8 + i), 32'h0, 0));
    // timeout, then pready on the last allowed cycle at the top address
    run_round(1'b1, 1'b0, mk(1'b0, 5'h05, 32'h0, NEVER), z);
    run_round(1'b1, 1'b0, mk(1'b1, 5'h1F, 32'hDEAD_BEEF, TO - 1), z);
    run_round(1'b0, 1'b1, z, mk(1'b0, 5'h1F, 32'h0, TO - 1));

    // reset while in ACCESS: no response, arbiter pointer restored
    plan(0, mk(1'b0, 5'h07, 32'h0, NEVER), 1'b0);
    drive_and_wait(1'b1, 1'b0, mk(1'b0, 5'h07, 32'h0, NEVER), z);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_psel", {63'd0, psel}, 64'd0);
    chk("midrst_penable", {63'd0, penable}, 64'd0);
    last_m = 1'b1;
    apb_q.delete();
    wq.delete();
    repeat (3) @(negedge clk);
    run_round(1'b1, 1'b1, mk(1'b0, 5'h03, 32'h0, 0), mk(1'b0, 5'h1F, 32'h0, 0));

    for (int i = 0; i < 150; i++) begin
      int p;
      p = $urandom_range(0, 2);
      run_round(p != 1, p != 0, rnd_cmd(), rnd_cmd());
    end

    repeat (5) @(negedge clk);
    chk("leftover_exp", exp_q0.size() + exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

endmodule
